queue_fifo4: RTL
================

# queue_fifo4

Four-entry, show-ahead, synchronous FIFO that feeds the queue occupancy decoder. It buffers WIDTH-bit words and publishes its fill level as a 4-bit thermometer code, `occ`. The code format is the one the decoder consumes directly: bit i is set iff more than i entries are held. It sits between the request producer and the downstream consumer, and exposes full/empty flags plus an optional protocol-error flag.

## Interface
- `WIDTH`, default 16: data word width in bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in`  in  WIDTH  write data, sampled when `wr_en` is high.
- `wr_en`  in  1  push request.
- `rd_en`  in  1  pop request.
- `data_out`  out  WIDTH  head entry (show-ahead); 0 when empty.
- `full`  out  1  high when 4 entries are held.
- `empty`  out  1  high when 0 entries are held.
- `occ`  out  4  thermometer fill level: 0000, 0001, 0011, 0111, 1111 for 0–4 entries.
- `err`  out  1  sticky protocol error (see Configuration).

## Operation
- **Storage:** 4×WIDTH register array, 2-bit `wr_ptr` and `rd_ptr`, and a 3-bit count 0–4.
  - Pointers wrap 3→0.
  - `occ`, `full` and `empty` are decoded from count. They are never stored independently.
- **Accepted push:** `wr_en & (~full | rd_en)`.
  - Writes `data_in` to `mem[wr_ptr]`, then `wr_ptr` increments.
- **Accepted pop:** `rd_en & ~empty`.
  - `rd_ptr` increments.
- **Count update:**
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- **Boundary cases:**
  - Push when full, no pop: ignored. Memory, pointers and count are unchanged.
  - Push + pop when full: both accepted; count stays 4. The popped word is the old head. The new word goes into the freed slot, because `wr_ptr == rd_ptr` when full.
  - Pop when empty: ignored.
  - Push + pop when empty: push accepted, pop ignored; count becomes 1.
- **Output decode:**
  - `data_out` = `mem[rd_ptr]` when `~empty`, else all zeros. This is purely combinational from the registered pointer and memory.
  - `occ[i]` = (count > i), for i = 0..3.
- **Reset:**
  - Pointers, count and `err` go to 0, so `empty`=1, `full`=0, `occ`=0000 and `data_out`=0.
  - Memory contents are not reset.
  - Reset asserted mid-stream discards all held entries on that edge. `wr_en` and `rd_en` are ignored in the reset cycle.

## Timing
- Single clock domain. Every register updates only on the rising edge of `clk`.
- **Write-to-read latency:** a word pushed into an empty FIFO on edge N appears on `data_out` after edge N. It can be popped with `rd_en` in the cycle following edge N.
- **Pop advance:** `data_out` advances to the next entry immediately after the popping edge.
- **Flag timing:** `full`, `empty`, `occ` and `err` reflect the state after the most recent edge. There are no combinational paths from `wr_en`/`rd_en` to these outputs.
- **Request decoding:** `rd_en` affects push acceptance combinationally (pop frees a slot when full). This path is internal to the next-state logic only.
- **Throughput:** one push and one pop per cycle, sustained at any fill level.

## Configuration
- Macro: `QUEUE_FIFO_ERR_CHK_EN`.
- **Defined:** `err` sets on the edge where either protocol error occurs:
  - push rejected (`wr_en & full & ~rd_en`), or
  - pop rejected (`rd_en & empty`).
  - Once set, `err` stays high until `rst`.
  - FIFO data behaviour is unchanged; the rejected request is still ignored.
- **Undefined:** `err` is tied to 0 and no error logic is synthesized. All other behaviour is identical.

## Test plan
- **Reset:** assert `rst` 1 cycle with `wr_en`=`rd_en`=1 → after edge: `empty`=1, `full`=0, `occ`=0000, `data_out`=0, `err`=0.
- **Fill and drain:**
  - Push 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles → `occ` steps 0001, 0011, 0111, 1111; `full`=1 after the 4th.
  - Then pop 4 times → `data_out` shows 0x1111..0x4444 in order; `occ` steps back to 0000; `empty`=1.
- **Overflow:**
  - From full, push 0x5555 with no pop → count stays 4 and the head stays 0x1111.
  - With the macro defined, `err`=1 after that edge and stays 1.
  - Without the macro, `err`=0.
- **Simultaneous push/pop when full:** push 0xAAAA with pop → `occ` stays 1111 and `data_out` becomes the second-oldest word. After four further pops the last value out is 0xAAAA.
- **Simultaneous push/pop when empty:** push 0xBEEF with pop → `occ`=0001 and `data_out`=0xBEEF. With the macro, `err` sets (rejected pop).
- **Wrap and mid-stream reset:**
  - Run 10 interleaved push/pop cycles so the pointers wrap → data order is preserved.
  - Then assert `rst` with 3 entries held → `empty`=1 and `data_out`=0 on the next cycle.

Source files
------------

// File: rtl/queue_fifo4_if.sv
// queue_fifo4_if: handshake/data bundle for the 4-entry show-ahead FIFO.
//   data_in  : write word         wr_en : push request    rd_en : pop request
//   data_out : head word (0 when empty)
//   full / empty : fill flags     occ : thermometer fill level
//   err      : sticky protocol error
// Modports: master = producer/consumer side, slave = FIFO side.
interface queue_fifo4_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data_in;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [3:0]       occ;
  logic             err;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, full, empty, occ, err
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, full, empty, occ, err
  );
endinterface

// File: rtl/queue_fifo4.sv
// queue_fifo4: four-entry show-ahead synchronous FIFO.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (pointers, count, err)
//   bus  : queue_fifo4_if.slave
//          data_in/wr_en push, rd_en pop, data_out head (0 when empty),
//          full/empty flags, occ thermometer (bit i set iff count > i), err.
// Optional feature macro: QUEUE_FIFO_ERR_CHK_EN
//   defined   -> err latches on a rejected push (full, no pop) or rejected pop
//                (empty) and holds until rst.
//   undefined -> err tied low.
// Flags and occ are decoded from the registered count only, so there is no
// combinational path from wr_en/rd_en to any output.
module queue_fifo4 #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  queue_fifo4_if.slave bus
);

  logic [3:0][WIDTH-1:0] mem;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [3:0]            occ;

  assign full  = (count == 3'd4);
  assign empty = (count == 3'd0);

  // A pop in the same cycle frees the slot a full FIFO would need; when full
  // wr_ptr == rd_ptr, so the new word lands exactly in the slot being popped.
  assign push = bus.wr_en & (~full | bus.rd_en);
  assign pop  = bus.rd_en & ~empty;

  // Storage is not reset; writes are masked during reset so the reset cycle
  // leaves no trace of wr_en.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < 4; i++) occ[i] = (count > 3'(i));
  end

  assign bus.data_out = empty ? '0 : mem[rd_ptr];
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.occ      = occ;

`ifdef QUEUE_FIFO_ERR_CHK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if ((bus.wr_en & full & ~bus.rd_en) | (bus.rd_en & empty)) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
